// File: rtl/seq_det_scheduler_if.sv
// Request/response handshake bundle for seq_det_scheduler.
// A valid/ready transfer completes on a rising clk edge where both valid and ready are high; the
// producer holds valid and its payload stable until that edge.
interface seq_det_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter int CW     = $clog2(WIDTH + 1),
  parameter int CHW    = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH*WIDTH-1:0] req_data;
  logic [NUM_CH-1:0]       req_ready;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [CHW-1:0]          resp_ch;
  logic [CW-1:0]           resp_count;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_ch, resp_count
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_ch, resp_count
  );
endinterface

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one external 101010 Mealy detector between NUM_CH requesters.
// Each granted word is shifted MSB-first into the detector and its match pulses are counted.
module seq_det_scheduler #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter int CW     = $clog2(WIDTH + 1),
  parameter int CHW    = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               reset,
  seq_det_scheduler_if.slave bus,
  output logic               busy,
  output logic               det_x,
  output logic               det_reset,
  input  logic               det_z,
  output logic [1:0]         dbg_state,
  output logic [CHW-1:0]     dbg_ptr
);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CHW-1:0]   ptr;
  logic [CHW-1:0]   ch_q;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    count;
  logic             resp_valid_q;
  logic             busy_q;

  logic             grant_found;
  logic [CHW-1:0]   grant_idx;
  logic [CHW-1:0]   next_ptr;
  logic [WIDTH-1:0] words [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_words
    assign words[i] = bus.req_data[i*WIDTH +: WIDTH];
  end

  // Walk from ptr downwards in priority so the lowest offset from ptr is written last and wins.
  always_comb begin
    int idx;
    logic [CHW-1:0] sel;
    idx         = 0;
    sel         = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_CH;
      sel = CHW'(idx);
      if (bus.req_valid[sel]) begin
        grant_found = 1'b1;
        grant_idx   = sel;
      end
    end
    next_ptr = CHW'((int'(grant_idx) + 1) % NUM_CH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      ch_q         <= '0;
      sr           <= '0;
      bit_cnt      <= '0;
      count        <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            sr     <= words[grant_idx];
            ch_q   <= grant_idx;
            count  <= '0;
            ptr    <= next_ptr;
            busy_q <= 1'b1;
            state  <= CLR;
          end
        end
        CLR: begin
          bit_cnt <= BW'(WIDTH - 1);
          state   <= SHIFT;
        end
        SHIFT: begin
          // det_z belongs to the bit currently on det_x, so it is counted on this same edge.
          if (det_z && (count != '1)) count <= count + 1'b1;
          sr      <= {sr[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == '0) begin
            resp_valid_q <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE && grant_found) ? (NUM_CH'(1) << grant_idx) : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_ch    = ch_q;
  assign bus.resp_count = count;
  assign busy           = busy_q;
  assign det_x          = (state == SHIFT) & sr[WIDTH-1];
  assign det_reset      = reset | (state == CLR);
  assign dbg_state      = state;
  assign dbg_ptr        = ptr;
endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: external detector model, cycle-exact monitor with an expected
// queue, table-driven single jobs, directed corner sequences and randomized traffic.
`timescale 1ns/1ps
module tb_seq_det_scheduler;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 16;
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int CHW    = $clog2(NUM_CH);
  localparam int EW     = CHW + CW;

  logic           clk = 1'b0;
  logic           reset;
  logic           busy, det_x, det_reset, det_z;
  logic [1:0]     dbg_state;
  logic [CHW-1:0] dbg_ptr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  seq_det_scheduler_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

  seq_det_scheduler #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .busy      (busy),
    .det_x     (det_x),
    .det_reset (det_reset),
    .det_z     (det_z),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External overlapping 101010 Mealy detector: z fires on the final 0 after seeing 10101.
  logic [4:0] det_hist = '0;
  int         det_len  = 0;
  always @(posedge clk) begin
    if (det_reset) begin
      det_hist <= '0;
      det_len  <= 0;
    end else begin
      det_hist <= {det_hist[3:0], det_x};
      if (det_len < 5) det_len <= det_len + 1;
    end
  end
  assign det_z = (det_len >= 5) && (det_hist == 5'b10101) && !det_x;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t bound expired", name, $time);
  endtask

  // Reference: count 101010 windows (overlapping) in the word read MSB-first.
  function automatic int ref_count(input logic [WIDTH-1:0] w);
    bit q[$];
    int c;
    c = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      q.push_back(w[i]);
      if (q.size() > 6) void'(q.pop_front());
      if (q.size() == 6 && q[0] && !q[1] && q[2] && !q[3] && q[4] && !q[5]) c++;
    end
    return c;
  endfunction

  // scoreboard / monitor
  bit               m_idle = 1'b1;
  int               m_ptr  = 0;
  int               job_start = 0;
  logic [WIDTH-1:0] job_word  = '0;
  logic [EW-1:0]    exp_q[$];
  int               log_ch[$];
  int               log_cnt[$];

  always @(negedge clk) begin
    logic [NUM_CH-1:0] exp_rdy;
    int win;
    int rel;
    bit exp_rv;
    if (reset) begin
      m_idle = 1'b1;
      m_ptr  = 0;
      exp_q.delete();
      check("rst_det_reset", det_reset, 1);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_det_x", det_x, 0);
      check("rst_resp_ch", bus.resp_ch, 0);
      check("rst_resp_count", bus.resp_count, 0);
    end else begin
      exp_rdy = '0;
      win     = -1;
      if (m_idle)
        for (int k = NUM_CH - 1; k >= 0; k--)
          if (bus.req_valid[(m_ptr + k) % NUM_CH]) win = (m_ptr + k) % NUM_CH;
      if (win >= 0) exp_rdy[win] = 1'b1;
      check("req_ready", bus.req_ready, exp_rdy);
      check("busy", busy, !m_idle);
      rel    = cyc - job_start;
      exp_rv = !m_idle && (rel >= WIDTH + 2);
      check("det_reset", det_reset, !m_idle && rel == 1);
      check("det_x", det_x,
            (!m_idle && rel >= 2 && rel <= WIDTH + 1) ? job_word[WIDTH+1-rel] : 1'b0);
      check("resp_valid", bus.resp_valid, exp_rv);
      if (exp_rv) begin
        if (exp_q.size() == 0) fail_now("resp_unexpected");
        else check("resp_hold", {bus.resp_ch, bus.resp_count}, exp_q[0]);
        if (bus.resp_ready) begin
          log_ch.push_back(int'(bus.resp_ch));
          log_cnt.push_back(int'(bus.resp_count));
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          m_idle = 1'b1;
        end
      end
      if (win >= 0) begin
        m_idle    = 1'b0;
        job_start = cyc;
        job_word  = bus.req_data[win*WIDTH +: WIDTH];
        exp_q.push_back({CHW'(win), CW'(ref_count(job_word))});
        m_ptr     = (win + 1) % NUM_CH;
      end
    end
  end

  // driver tasks
  function automatic logic [WIDTH-1:0] rand_word();
    logic [31:0] r;
    logic [WIDTH-1:0] a;
    r = $urandom;
    a = 16'hAAAA;
    case ($urandom_range(0, 3))
      0:       return r[WIDTH-1:0];
      1:       return a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      2:       return r[WIDTH-1:0] & a;
      default: return WIDTH'(16'h002A) << $urandom_range(0, 10);
    endcase
  endfunction

  task automatic step(input bit rand_req, input bit rand_rdy);
    logic [NUM_CH-1:0] rdy;
    @(negedge clk);
    rdy = bus.req_ready;
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~rdy;
    if (rand_rdy) bus.resp_ready = ($urandom_range(0, 3) != 0);
    if (rand_req)
      for (int i = 0; i < NUM_CH; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 5) == 0) begin
          bus.req_data[i*WIDTH +: WIDTH] = rand_word();
          bus.req_valid[i] = 1'b1;
        end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.req_valid = '0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_one(input int ch, input logic [WIDTH-1:0] d, input int exp_cnt);
    int n, g_n;
    @(posedge clk);
    #1;
    bus.req_data[ch*WIDTH +: WIDTH] = d;
    bus.req_valid[ch] = 1'b1;
    bus.resp_ready = 1'b1;
    n = 0;
    g_n = -1;
    while (n < 100) begin
      @(negedge clk);
      if (bus.resp_valid) break;
      if (bus.req_ready[ch]) begin
        g_n = n;
        @(posedge clk);
        #1;
        bus.req_valid[ch] = 1'b0;
      end
      n++;
    end
    if (n >= 100) fail_now("run_one_timeout");
    else begin
      check("job_latency", n - g_n, WIDTH + 2);
      check("job_resp_ch", bus.resp_ch, ch);
      check("job_resp_count", bus.resp_count, exp_cnt);
    end
    @(posedge clk);
  endtask

  typedef struct {
    int               ch;
    logic [WIDTH-1:0] data;
    int               cnt;
  } vec_t;

  vec_t vecs[8];
  int   exp4[4];

  initial begin
    int n;
    vecs[0] = '{0, 16'h002A, 1};
    vecs[1] = '{2, 16'hAAAA, 6};
    vecs[2] = '{1, 16'hFFFF, 0};
    vecs[3] = '{3, 16'h0000, 0};
    vecs[4] = '{0, 16'h5555, 5};
    vecs[5] = '{2, 16'hA800, 1};
    vecs[6] = '{1, 16'h2A2A, 2};
    vecs[7] = '{3, 16'h0015, 0};
    exp4    = '{0, 1, 6, 0};

    reset = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_state", dbg_state, 0);
    check("post_rst_ptr", dbg_ptr, 0);
    check("post_rst_det_reset", det_reset, 0);

    for (int i = 0; i < 8; i++) run_one(vecs[i].ch, vecs[i].data, vecs[i].cnt);

    // all four channels request together from ptr 0
    do_reset(2);
    log_ch.delete();
    log_cnt.delete();
    @(posedge clk);
    #1;
    bus.req_data  = {16'hFFFF, 16'hAAAA, 16'h002A, 16'h0000};
    bus.req_valid = 4'hF;
    n = 0;
    while (log_ch.size() < 4 && n < 200) begin step(0, 0); n++; end
    if (log_ch.size() < 4) fail_now("all4_timeout");
    else
      for (int i = 0; i < 4; i++) begin
        check("all4_order", log_ch[i], i);
        check("all4_count", log_cnt[i], exp4[i]);
      end
    @(negedge clk);
    check("all4_ptr", dbg_ptr, 0);

    // backpressure in DONE with another request pending
    log_ch.delete();
    log_cnt.delete();
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    bus.req_data[1*WIDTH +: WIDTH] = 16'h2A2A;
    bus.req_data[3*WIDTH +: WIDTH] = 16'h5555;
    bus.req_valid = 4'b1010;
    n = 0;
    while (!bus.resp_valid && n < 100) begin step(0, 0); n++; end
    if (n >= 100) fail_now("bp_timeout");
    repeat (10) begin
      @(negedge clk);
      check("bp_resp_valid", bus.resp_valid, 1);
      check("bp_resp_ch", bus.resp_ch, 1);
      check("bp_resp_count", bus.resp_count, 2);
      check("bp_no_grant", bus.req_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    n = 0;
    while (log_ch.size() < 2 && n < 100) begin step(0, 0); n++; end
    if (log_ch.size() < 2) fail_now("bp_drain_timeout");
    else begin
      check("bp_first_ch", log_ch[0], 1);
      check("bp_second_ch", log_ch[1], 3);
      check("bp_second_count", log_cnt[1], 5);
    end

    // reset in the middle of SHIFT aborts the job
    @(posedge clk);
    #1;
    bus.req_data[0*WIDTH +: WIDTH] = 16'hAAAA;
    bus.req_valid[0] = 1'b1;
    n = 0;
    while (!bus.req_ready[0] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("abort_grant_timeout");
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    repeat (9) @(posedge clk);
    do_reset(2);
    repeat (25) begin
      @(negedge clk);
      check("abort_no_resp", bus.resp_valid, 0);
      check("abort_idle", dbg_state, 0);
    end
    run_one(1, 16'h002A, 1);

    // randomized traffic against the monitor's model
    repeat (800) step(1, 1);
    bus.resp_ready = 1'b1;
    n = 0;
    while ((bus.req_valid != '0 || !m_idle) && n < 400) begin step(0, 0); n++; end
    if (n >= 400) fail_now("drain_timeout");
    @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
